// File: rtl/snn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : snn_pkg                                                    |
// | Description : Shared types and helpers for the SNN step scheduler:       |
// |               FSM state encoding, a constant-safe ceil(log2) helper and  |
// |               the default per-neuron spike counter width.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package snn_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_STEP   = 3'd3,
    S_SAMPLE = 3'd4,
    S_DECIDE = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

  // ceil(log2(n)); returns 0 for n <= 1. Usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_argmax_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : snn_argmax_seq                                             |
// | Description : Serial argmax. One (idx, val) candidate per enabled cycle; |
// |               the running best is replaced only on a strictly greater    |
// |               value, so ties resolve to the earliest-presented index.    |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst   - clock, async active-high reset                |
// |               en         - a candidate is presented this cycle           |
// |               start      - candidate is the first of a new scan          |
// |               idx, val   - candidate index and value                     |
// |               best_idx/  - best so far INCLUDING this cycle's candidate   |
// |               best_val                                                   |
// |               done       - this cycle's candidate is the last index      |
// +--------------------------------------------------------------------------+
module snn_argmax_seq
  import snn_pkg::*;
#(
  parameter int NUM_OUTPUTS = 4,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            start,
  input  logic [clog2(NUM_OUTPUTS)-1:0]   idx,
  input  logic [CNT_W-1:0]                val,
  output logic [clog2(NUM_OUTPUTS)-1:0]   best_idx,
  output logic [CNT_W-1:0]                best_val,
  output logic                            done
);

  localparam int IDX_W = clog2(NUM_OUTPUTS);

  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_val_q, best_val_d;

  always_comb begin
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (en) begin
      // start discards whatever a previous scan left behind
      if (start || (val > best_val_q)) begin
        best_idx_d = idx;
        best_val_d = val;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  // Expose the updated best so the caller can latch the final result in the
  // same cycle the last candidate is presented.
  assign best_idx = best_idx_d;
  assign best_val = best_val_d;
  assign done     = en && (idx == IDX_W'(NUM_OUTPUTS - 1));

endmodule
`default_nettype wire

// File: rtl/snn_step_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : snn_step_scheduler                                         |
// | Description : Sequences one IF-neuron layer through an inference of      |
// |               NUM_STEPS timesteps: clear, then per step fetch a spike    |
// |               vector, strobe the layer, count output spikes. Finally a   |
// |               serial argmax reports the winning class.                   |
// | Revision    : 1.0 - initial release                                      |
// | Ports       : clk, rst        - clock, async active-high reset           |
// |               start           - begin inference (IDLE only)              |
// |               in_valid/ready, in_spikes - input spike vector handshake   |
// |               layer_clr       - one-cycle clear of neuron potentials     |
// |               step_en         - one-cycle layer update strobe            |
// |               layer_spk_in    - vector to layer, zero unless step_en     |
// |               layer_spk_out   - layer spikes (combinational from layer)  |
// |               res_valid/ready, res_class, res_none - result handshake    |
// |               busy            - high in every state except IDLE          |
// +--------------------------------------------------------------------------+
module snn_step_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int NUM_STEPS   = 16,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  input  logic [NUM_INPUTS-1:0]          in_spikes,
  output logic                           in_ready,
  output logic                           layer_clr,
  output logic                           step_en,
  output logic [NUM_INPUTS-1:0]          layer_spk_in,
  input  logic [NUM_OUTPUTS-1:0]         layer_spk_out,
  output logic                           res_valid,
  output logic [clog2(NUM_OUTPUTS)-1:0]  res_class,
  output logic                           res_none,
  input  logic                           res_ready,
  output logic                           busy
);

  localparam int IDX_W = clog2(NUM_OUTPUTS);
  localparam int SC_W  = clog2(NUM_STEPS + 1);

  state_t                state_q, state_d;
  logic [NUM_INPUTS-1:0] vec_q, vec_d;
  logic [SC_W-1:0]       step_q, step_d;
  logic [IDX_W-1:0]      scan_q, scan_d;
  logic [CNT_W-1:0]      cnt_q [NUM_OUTPUTS];
  logic [CNT_W-1:0]      cnt_d [NUM_OUTPUTS];
  logic [IDX_W-1:0]      res_class_q, res_class_d;
  logic                  res_none_q, res_none_d;

  logic                  am_en;
  logic                  am_start;
  logic [IDX_W-1:0]      am_best_idx;
  logic [CNT_W-1:0]      am_best_val;
  logic                  am_done;

  assign am_en    = (state_q == S_DECIDE);
  assign am_start = (scan_q == '0);

  snn_argmax_seq #(
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .CNT_W       (CNT_W)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .en       (am_en),
    .start    (am_start),
    .idx      (scan_q),
    .val      (cnt_q[scan_q]),
    .best_idx (am_best_idx),
    .best_val (am_best_val),
    .done     (am_done)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    step_d      = step_q;
    scan_d      = scan_q;
    cnt_d       = cnt_q;
    res_class_d = res_class_q;
    res_none_d  = res_none_q;
    in_ready    = 1'b0;
    layer_clr   = 1'b0;
    step_en     = 1'b0;
    res_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end

      S_CLEAR: begin
        layer_clr = 1'b1;
        for (int i = 0; i < NUM_OUTPUTS; i++) cnt_d[i] = '0;
        step_d  = '0;
        state_d = S_FETCH;
      end

      S_FETCH: begin
        in_ready = 1'b1;
        if (in_valid) begin
          vec_d   = in_spikes;
          state_d = S_STEP;
        end
      end

      S_STEP: begin
        step_en = 1'b1;
        state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        // Layer outputs now reflect the potentials updated by the strobe.
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
          if (layer_spk_out[i] && (cnt_q[i] != {CNT_W{1'b1}}))
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        step_d = step_q + SC_W'(1);
        if (step_d == SC_W'(NUM_STEPS)) begin
          scan_d  = '0;
          state_d = S_DECIDE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECIDE: begin
        scan_d = scan_q + IDX_W'(1);
        if (am_done) begin
          res_none_d  = (am_best_val == '0);
          res_class_d = (am_best_val == '0) ? '0 : am_best_idx;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      step_q      <= '0;
      scan_q      <= '0;
      res_class_q <= '0;
      res_none_q  <= 1'b0;
      for (int i = 0; i < NUM_OUTPUTS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      step_q      <= step_d;
      scan_q      <= scan_d;
      res_class_q <= res_class_d;
      res_none_q  <= res_none_d;
      cnt_q       <= cnt_d;
    end
  end

  assign layer_spk_in = step_en ? vec_q : '0;
  assign res_class    = res_class_q;
  assign res_none     = res_none_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snn_step_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_snn_step_scheduler                                      |
// | Description : Self-checking bench. Two scheduler instances: A with       |
// |               4 steps / 8-bit counters, B with 16 steps / 2-bit counters.|
// |               Each drives an identity layer model: output neuron i       |
// |               spikes in the SAMPLE cycle iff input bit i was strobed.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_snn_step_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic       a_start = 0, a_in_valid = 0, a_res_ready = 0;
  logic [3:0] a_in_spikes = 0;
  logic       a_in_ready, a_layer_clr, a_step_en, a_res_valid, a_res_none, a_busy;
  logic [3:0] a_layer_spk_in, a_layer_spk_out, a_lay;
  logic [1:0] a_res_class;

  snn_step_scheduler #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .NUM_STEPS(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .in_valid(a_in_valid), .in_spikes(a_in_spikes),
    .in_ready(a_in_ready), .layer_clr(a_layer_clr), .step_en(a_step_en),
    .layer_spk_in(a_layer_spk_in), .layer_spk_out(a_layer_spk_out),
    .res_valid(a_res_valid), .res_class(a_res_class), .res_none(a_res_none),
    .res_ready(a_res_ready), .busy(a_busy));

  // ---------------- instance B ----------------
  logic       b_start = 0, b_in_valid = 0, b_res_ready = 0;
  logic [3:0] b_in_spikes = 0;
  logic       b_in_ready, b_layer_clr, b_step_en, b_res_valid, b_res_none, b_busy;
  logic [3:0] b_layer_spk_in, b_layer_spk_out, b_lay;
  logic [1:0] b_res_class;

  snn_step_scheduler #(.NUM_INPUTS(4), .NUM_OUTPUTS(4), .NUM_STEPS(16), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_spikes(b_in_spikes),
    .in_ready(b_in_ready), .layer_clr(b_layer_clr), .step_en(b_step_en),
    .layer_spk_in(b_layer_spk_in), .layer_spk_out(b_layer_spk_out),
    .res_valid(b_res_valid), .res_class(b_res_class), .res_none(b_res_none),
    .res_ready(b_res_ready), .busy(b_busy));

  // Identity layer: spikes visible only in the cycle after the strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_lay <= 4'b0;
      b_lay <= 4'b0;
    end else begin
      a_lay <= a_step_en ? a_layer_spk_in : 4'b0;
      b_lay <= b_step_en ? b_layer_spk_in : 4'b0;
    end
  end
  assign a_layer_spk_out = a_lay;
  assign b_layer_spk_out = b_lay;

  // Handshake / strobe counters and protocol-rule violations.
  int acc_a = 0, stp_a = 0, acc_b = 0, viol = 0;
  always @(posedge clk) begin
    if (a_in_valid && a_in_ready) acc_a <= acc_a + 1;
    if (a_step_en)                stp_a <= stp_a + 1;
    if (b_in_valid && b_in_ready) acc_b <= acc_b + 1;
    if ((a_layer_clr && a_step_en) || (b_layer_clr && b_step_en)) viol <= viol + 1;
    if (a_in_ready && (a_step_en || a_layer_clr || a_res_valid))  viol <= viol + 1;
    if ((!a_step_en && a_layer_spk_in != 4'b0) || (!b_step_en && b_layer_spk_in != 4'b0))
      viol <= viol + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: v holds step k's vector in bits [4k+3:4k]; count spikes per
  // neuron over the steps, pick the largest, earliest index on ties.
  function automatic void model(input logic [15:0] v, output logic [1:0] cls, output logic none);
    int c [4];
    int best;
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 4; i++) c[i] += int'(v[s*4 + i]);
    best = 0;
    for (int i = 1; i < 4; i++) if (c[i] > c[best]) best = i;
    none = (c[best] == 0);
    cls  = none ? 2'd0 : 2'(best);
  endfunction

  // One full inference on instance A with an optional FETCH stall before
  // step st_step and a res_ready delay of rdy cycles.
  task automatic run_a(input string nm, input logic [15:0] v, input int st_step, input int st_len,
                       input int rdy, input logic [1:0] ecls, input logic enone);
    int  cyc, k, stall_left, base_acc, base_stp;
    bit  got;
    base_acc   = acc_a;
    base_stp   = stp_a;
    stall_left = st_len;
    got        = 0;
    @(negedge clk); a_start = 1;
    @(negedge clk); a_start = 0; cyc = 1;
    while (!got && cyc < 400) begin
      k = acc_a - base_acc;
      if (a_res_valid) begin
        got = 1;
        a_in_valid = 0;
      end else begin
        if (k < 4) begin
          a_in_spikes = v[k*4 +: 4];
          if (k == st_step && stall_left > 0) begin
            a_in_valid = 0;
            if (a_in_ready) stall_left--;
          end else begin
            a_in_valid = 1;
          end
        end else begin
          a_in_valid  = 0;
          a_in_spikes = 4'hF;
        end
        @(negedge clk); cyc++;
      end
    end
    if (!got) begin
      chk({nm, "_timeout"}, 0, 1);
      a_in_valid = 0;
      return;
    end
    chk({nm, "_latency"}, cyc, 18 + st_len);
    chk({nm, "_class"}, a_res_class, ecls);
    chk({nm, "_none"}, a_res_none, enone);
    chk({nm, "_vectors"}, acc_a - base_acc, 4);
    chk({nm, "_steps"}, stp_a - base_stp, 4);
    for (int d = 0; d < rdy; d++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, a_res_valid, 1);
      chk({nm, "_hold_class"}, a_res_class, ecls);
    end
    // start raised together with the handshake must be ignored
    a_res_ready = 1; a_start = 1;
    @(negedge clk); a_res_ready = 0; a_start = 0;
    chk({nm, "_valid_drop"}, a_res_valid, 0);
    chk({nm, "_idle"}, a_busy, 0);
    @(negedge clk);
    chk({nm, "_start_ignored"}, a_busy, 0);
  endtask

  typedef struct {
    string      nm;
    logic [15:0] v;
    int         st_step;
    int         st_len;
    int         rdy;
    logic [1:0] cls;
    logic       none;
  } vec_t;

  vec_t tbl [6];

  initial begin : main
    int   k, cyc;
    bit   hit;
    logic [15:0] rv;
    logic [1:0]  ecls;
    logic        enone;
    int   sst, sln, rdy;

    tbl[0] = '{"basic",   16'h4144, 0, 0, 0, 2'd2, 1'b0};
    tbl[1] = '{"tie",     16'h0A82, 0, 0, 2, 2'd1, 1'b0};
    tbl[2] = '{"nospike", 16'h0000, 0, 0, 1, 2'd0, 1'b1};
    tbl[3] = '{"stall",   16'h4144, 2, 5, 0, 2'd2, 1'b0};
    tbl[4] = '{"alltie",  16'hFFFF, 0, 0, 3, 2'd0, 1'b0};
    tbl[5] = '{"last",    16'h1898, 1, 2, 1, 2'd3, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs_a", {a_in_ready, a_layer_clr, a_step_en, a_layer_spk_in,
                            a_res_valid, a_res_class, a_res_none, a_busy}, 0);
    chk("reset_busy_b", b_busy, 0);
    rst = 0;
    @(negedge clk);

    // Table-driven inferences
    for (int t = 0; t < 6; t++) begin
      run_a(tbl[t].nm, tbl[t].v, tbl[t].st_step, tbl[t].st_len, tbl[t].rdy, tbl[t].cls, tbl[t].none);
      if (t == 0) begin
        chk("basic_cnt0", dut_a.cnt_q[0], 1);
        chk("basic_cnt1", dut_a.cnt_q[1], 0);
        chk("basic_cnt2", dut_a.cnt_q[2], 3);
        chk("basic_cnt3", dut_a.cnt_q[3], 0);
      end
    end

    // Randomized inferences against the reference model
    for (int r = 0; r < 25; r++) begin
      rv  = (r % 2 == 0) ? 16'($urandom) : 16'($urandom & $urandom & $urandom);
      sst = $urandom_range(0, 3);
      sln = $urandom_range(0, 3);
      rdy = $urandom_range(0, 3);
      model(rv, ecls, enone);
      run_a("rand", rv, sst, sln, rdy, ecls, enone);
    end

    // Reset during step 2 (neuron 3 spiking), then a clean inference
    hit = 0;
    k   = acc_a;
    @(negedge clk); a_start = 1;
    @(negedge clk); a_start = 0;
    a_in_spikes = 4'b1000;
    a_in_valid  = 1;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (acc_a - k == 3 && a_step_en) hit = 1;
    end
    chk("rst_reached_step2", hit, 1);
    rst = 1;
    #1;
    chk("rst_outputs_now", {a_in_ready, a_layer_clr, a_step_en, a_layer_spk_in,
                            a_res_valid, a_res_class, a_res_none, a_busy}, 0);
    @(negedge clk);
    chk("rst_outputs_next", {a_in_ready, a_layer_clr, a_step_en, a_layer_spk_in,
                             a_res_valid, a_res_class, a_res_none, a_busy}, 0);
    a_in_valid = 0;
    rst = 0;
    @(negedge clk);
    run_a("after_rst", 16'h0011, 0, 0, 0, 2'd0, 1'b0);
    chk("after_rst_cnt3", dut_a.cnt_q[3], 0);
    chk("after_rst_cnt0", dut_a.cnt_q[0], 2);

    // Saturation on B: neuron 0 spikes all 16 steps (saturates at 3),
    // neuron 1 spikes 3 times; a wrapping counter would hand the win to 1.
    k = acc_b;
    @(negedge clk); b_start = 1;
    @(negedge clk); b_start = 0; cyc = 1;
    while (!b_res_valid && cyc < 300) begin
      b_in_valid  = (acc_b - k) < 16;
      b_in_spikes = ((acc_b - k) < 3) ? 4'b0011 : 4'b0001;
      @(negedge clk); cyc++;
    end
    b_in_valid = 0;
    chk("sat_latency", cyc, 54);
    chk("sat_valid", b_res_valid, 1);
    chk("sat_class", b_res_class, 0);
    chk("sat_none", b_res_none, 0);
    chk("sat_cnt0", dut_b.cnt_q[0], 3);
    chk("sat_cnt1", dut_b.cnt_q[1], 3);
    chk("sat_vectors", acc_b - k, 16);
    for (int d = 0; d < 10; d++) begin
      @(negedge clk);
      chk("sat_hold_valid", b_res_valid, 1);
      chk("sat_hold_class", {b_res_class, b_res_none}, 0);
    end
    b_res_ready = 1;
    @(negedge clk); b_res_ready = 0;
    chk("sat_valid_drop", b_res_valid, 0);

    chk("protocol_violations", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
